// File: rtl/stall_unit.sv
// -----------------------------------------------------------------------------
// stall_unit
//   Responder side of the processor stall protocol. An instruction that moves a
//   value to STALL_ADDR holds the program counter. This block decodes that move,
//   times the stall (fixed count or wait for an external event), and then frees
//   the program counter with a single-cycle stall_override pulse.
//
// Ports
//   clk            in   1           system clock, rising-edge
//   rst            in   1           asynchronous, active-high reset
//   dest           in   7           destination field of the current instruction
//   src_val        in   DATA_WIDTH  value moved by the current instruction
//                                   [DATA_WIDTH-1]   mode (0 count, 1 event)
//                                   [DATA_WIDTH-2:0] cycle count (count mode)
//                                   [EVT_WIDTH-1:0]  event mask (event mode)
//   evt            in   EVT_WIDTH   external event lines, level, synchronous
//   stall_override out  1           registered release pulse to the PC
//   busy           out  1           registered, high in COUNT / WAIT_EVT
// -----------------------------------------------------------------------------
module stall_unit #(
    parameter logic [6:0] STALL_ADDR = 7'b0100001,
    parameter int         DATA_WIDTH = 8,
    parameter int         EVT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            dest,
    input  logic [DATA_WIDTH-1:0] src_val,
    input  logic [EVT_WIDTH-1:0]  evt,
    output logic                  stall_override,
    output logic                  busy
);

    localparam int CNT_W = DATA_WIDTH - 1;

    localparam logic [CNT_W-1:0]     CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_WIDTH-1:0] MASK_ZERO = {EVT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_WAIT_EVT = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [EVT_WIDTH-1:0] mask_q, mask_d;
    logic                 override_q, override_d;
    logic                 busy_q, busy_d;

    // Decoded fields of the incoming move; only consumed in IDLE.
    logic                 src_mode_s;
    logic [CNT_W-1:0]     src_cnt_s;
    logic [EVT_WIDTH-1:0] src_mask_s;

    assign src_mode_s = src_val[DATA_WIDTH-1];
    assign src_cnt_s  = src_val[DATA_WIDTH-2:0];
    assign src_mask_s = src_val[EVT_WIDTH-1:0];

    // Next-state, counter/mask and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (dest == STALL_ADDR) begin
                    cnt_d  = src_cnt_s;
                    mask_d = src_mask_s;
                    // Zero count or zero mask releases at once so it cannot deadlock.
                    if (!src_mode_s && (src_cnt_s != CNT_ZERO)) begin
                        state_d = ST_COUNT;
                    end else if (src_mode_s && (src_mask_s != MASK_ZERO)) begin
                        state_d = ST_WAIT_EVT;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                // cnt reaches 0 exactly when leaving COUNT, so it never wraps.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_WAIT_EVT: begin
                if ((mask_q & evt) != MASK_ZERO) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_WAIT_EVT;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        override_d = (state_d == ST_RELEASE);
        busy_d     = (state_d == ST_COUNT) || (state_d == ST_WAIT_EVT);
    end

    // State, timing registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            mask_q     <= MASK_ZERO;
            override_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            override_q <= override_d;
            busy_q     <= busy_d;
        end
    end

    assign stall_override = override_q;
    assign busy           = busy_q;

endmodule
